// File: rtl/sel_encoder_if.sv
// -----------------------------------------------------------------------------
// sel_encoder_if
// Request/result bundle for the sel_encoder one-hot priority encoder.
//   req        : N-bit request lines (one-hot intended), producer -> encoder
//   req_valid  : req is presented this cycle
//   req_ready  : encoder accepts req this cycle
//   code       : CW-bit encoded index, encoder -> consumer
//   code_valid : code holds an undelivered result
//   code_ready : consumer takes code this cycle
//   err_zero   : one-cycle pulse after an all-zero accept
//   err_multi  : one-cycle pulse after a multi-hot accept
//   err_cnt    : saturating count of err_multi pulses
// master : the environment (producer + consumer); slave : the encoder.
// -----------------------------------------------------------------------------
interface sel_encoder_if #(
    parameter int N  = 8,
    parameter int CW = 3
);
    logic [N-1:0]  req;
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] code;
    logic          code_valid;
    logic          code_ready;
    logic          err_zero;
    logic          err_multi;
    logic [7:0]    err_cnt;

    modport master (
        output req, req_valid, code_ready,
        input  req_ready, code, code_valid, err_zero, err_multi, err_cnt
    );

    modport slave (
        input  req, req_valid, code_ready,
        output req_ready, code, code_valid, err_zero, err_multi, err_cnt
    );
endinterface

// File: rtl/sel_encoder.sv
// -----------------------------------------------------------------------------
// sel_encoder
// Registered priority encoder with a one-deep valid/ready output stage.
// Highest set request bit wins. An accepted all-zero request is consumed
// without producing a code and flags err_zero. With the optional macro
// SEL_ENCODER_UNIQUE_CHECK_EN defined, accepted multi-hot requests pulse
// err_multi and bump a saturating 8-bit err_cnt; without it both read 0.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sel_encoder_if.slave (req/req_valid/req_ready, code/code_valid/
//           code_ready, err_zero, err_multi, err_cnt)
// Parameters: N request lines (power of two, 2..64), CW = log2(N).
// -----------------------------------------------------------------------------
module sel_encoder #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    sel_encoder_if.slave bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Highest set bit wins: later iterations overwrite lower matches.
    function automatic logic [CW-1:0] prio_enc(input logic [N-1:0] r);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                idx = i[CW-1:0];
            end
        end
        return idx;
    endfunction

`ifdef SEL_ENCODER_UNIQUE_CHECK_EN
    // Clearing the lowest set bit leaves something only if two or more were set.
    function automatic logic is_multi(input logic [N-1:0] r);
        return (r & (r - {{(N-1){1'b0}}, 1'b1})) != {N{1'b0}};
    endfunction
`endif

    state_t        state_r;
    logic [CW-1:0] code_r;
    logic          err_zero_r;

    logic          code_valid_s;
    logic          req_ready_s;
    logic          accept_s;
    logic          nonzero_s;
    logic          transfer_s;
    logic [CW-1:0] enc_s;

    assign code_valid_s = (state_r == FULL);
    // The stage frees up in the same cycle the consumer drains it.
    assign req_ready_s  = ~code_valid_s | bus.code_ready;
    assign accept_s     = bus.req_valid & req_ready_s;
    assign nonzero_s    = |bus.req;
    assign transfer_s   = code_valid_s & bus.code_ready;
    assign enc_s        = prio_enc(bus.req);

    // Output-stage FSM: holds the code until transferred, reloads back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= EMPTY;
            code_r     <= {CW{1'b0}};
            err_zero_r <= 1'b0;
        end else begin
            err_zero_r <= accept_s & ~nonzero_s;
            case (state_r)
                EMPTY: begin
                    if (accept_s && nonzero_s) begin
                        state_r <= FULL;
                        code_r  <= enc_s;
                    end else begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    // An accept while FULL implies code_ready=1, i.e. the old code leaves.
                    if (accept_s && nonzero_s) begin
                        state_r <= FULL;
                        code_r  <= enc_s;
                    end else if (transfer_s) begin
                        state_r <= EMPTY;
                    end else begin
                        state_r <= FULL;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

`ifdef SEL_ENCODER_UNIQUE_CHECK_EN
    logic       err_multi_r;
    logic [7:0] err_cnt_r;
    logic       multi_hit_s;

    assign multi_hit_s = accept_s & is_multi(bus.req);

    // Multi-hot pulse and saturating event counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_multi_r <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            err_multi_r <= multi_hit_s;
            if (multi_hit_s && (err_cnt_r != 8'd255)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    assign bus.err_multi = err_multi_r;
    assign bus.err_cnt   = err_cnt_r;
`else
    assign bus.err_multi = 1'b0;
    assign bus.err_cnt   = 8'd0;
`endif

    assign bus.req_ready  = req_ready_s;
    assign bus.code       = code_r;
    assign bus.code_valid = code_valid_s;
    assign bus.err_zero   = err_zero_r;

endmodule

// File: tb/tb_sel_encoder.sv
// -----------------------------------------------------------------------------
// tb_sel_encoder
// Directed scenarios followed by randomized traffic, each cycle compared with
// a behavioural model: expected code = floor(log2(req)), multi-hot = more than
// one bit set by population count, one-deep output buffer with valid/ready.
// -----------------------------------------------------------------------------
module tb_sel_encoder;

`ifdef SEL_ENCODER_UNIQUE_CHECK_EN
    localparam bit UNIQ = 1'b1;
`else
    localparam bit UNIQ = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    // model state
    bit m_valid;
    int m_code;
    bit m_ez;
    bit m_em;
    int m_cnt;

    sel_encoder_if #(.N(8), .CW(3)) bus ();

    sel_encoder #(.N(8), .CW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_code  = 0;
        m_ez    = 1'b0;
        m_em    = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic check_outputs();
        chk("code_valid", {31'd0, bus.code_valid}, {31'd0, m_valid});
        chk("code",       {29'd0, bus.code},       m_code);
        chk("err_zero",   {31'd0, bus.err_zero},   {31'd0, m_ez});
        chk("err_multi",  {31'd0, bus.err_multi},  {31'd0, m_em});
        chk("err_cnt",    {24'd0, bus.err_cnt},    m_cnt);
    endtask

    // One clock cycle: drive, check ready, predict, clock, check outputs.
    task automatic cycle(input logic [7:0] r, input logic rv, input logic cr);
        bit acc;
        bit rdy;
        bus.req        = r;
        bus.req_valid  = rv;
        bus.code_ready = cr;
        #1;
        rdy = !m_valid || cr;
        chk("req_ready", {31'd0, bus.req_ready}, {31'd0, rdy});
        acc = rv && rdy;
        m_ez = acc && (r == 8'd0);
        m_em = UNIQ && acc && ($countones(r) > 1);
        if (m_em && m_cnt < 255) m_cnt = m_cnt + 1;
        if (acc && r != 8'd0) begin
            m_valid = 1'b1;
            m_code  = $clog2(int'(r) + 1) - 1;
        end else if (m_valid && cr) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();

        // Reset held with a valid request presented
        rst_n          = 1'b0;
        bus.req        = 8'h08;
        bus.req_valid  = 1'b1;
        bus.code_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("rst_code_const", {29'd0, bus.code}, 32'd0);
        rst_n = 1'b1;

        // First edge after release accepts
        cycle(8'h08, 1'b1, 1'b0);
        chk("first_accept_code", {29'd0, bus.code}, 32'd3);

        // Backpressure: drain 3 while loading 0x80, then hold 3 cycles
        cycle(8'h80, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(8'h01, 1'b1, 1'b0);
        chk("bp_code_held", {29'd0, bus.code}, 32'd7);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h01, 1'b1, 1'b1);
        chk("bp_after_code", {29'd0, bus.code}, 32'd0);

        // Streaming
        cycle(8'h01, 1'b1, 1'b1);
        cycle(8'h02, 1'b1, 1'b1);
        cycle(8'h04, 1'b1, 1'b1);
        cycle(8'h08, 1'b1, 1'b1);
        chk("stream_last", {29'd0, bus.code}, 32'd3);

        // Zero request from the empty state
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b1, 1'b1);
        chk("zero_pulse", {31'd0, bus.err_zero}, 32'd1);
        cycle(8'h00, 1'b0, 1'b1);

        // Priority example
        cycle(8'h50, 1'b1, 1'b1);
        chk("prio_0x50", {29'd0, bus.code}, 32'd6);

        // Multi-hot and counter saturation
        cycle(8'h14, 1'b1, 1'b1);
        chk("multi_code", {29'd0, bus.code}, 32'd4);
        cycle(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) cycle(8'hC3, 1'b1, 1'b1);
        chk("cnt_sat", {24'd0, bus.err_cnt}, UNIQ ? 32'd255 : 32'd0);

        // Asynchronous reset between edges while FULL
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", {31'd0, bus.code_valid}, 32'd0);
        chk("async_rst_code",  {29'd0, bus.code},       32'd0);
        chk("async_rst_cnt",   {24'd0, bus.err_cnt},    32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] r;
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      r = 8'h00;
            else if (sel == 3) r = 8'($urandom);
            else               r = 8'(1 << $urandom_range(0, 7));
            cycle(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
